// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;
   localparam int NumOut     = 2;
   localparam int CountWidth = 16;
   typedef logic [CountWidth-1:0] count_t;
endpackage

// File: rtl/stream_demux_fifo.sv
// Per-output FIFO: registered storage, head word always visible on o_data.
// Latency 1 cycle push-to-empty-deassert; pushes to a full FIFO and pops from an empty one are ignored.
// Backpressure: o_full is the push-side ready (inverted), o_empty the pop-side valid (inverted).
module stream_demux_fifo #(
   parameter int ParamA     = 10,
   parameter int ParamDepth = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic [ParamA-1:0] i_data,
   output logic              o_full,
   input  logic              i_pop,
   output logic [ParamA-1:0] o_data,
   output logic              o_empty
);
   localparam int PtrW = (ParamDepth > 1) ? $clog2(ParamDepth) : 1;
   localparam int CntW = $clog2(ParamDepth + 1);

   logic [ParamA-1:0] mem_q [ParamDepth];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign o_full  = (cnt_q == CntW'(ParamDepth));
   assign o_empty = (cnt_q == '0);
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;
   assign o_data  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PtrW'(ParamDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrW'(ParamDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
      // simultaneous push and pop leaves occupancy unchanged
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < ParamDepth; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end
endmodule

// File: rtl/stream_demux.sv
// 1-to-2 stream demux routing each accepted word by i_sel into a per-output FIFO (STREAM_DEMUX_COUNT_EN adds pop counters).
// Latency 1 cycle from acceptance to o_valid on an empty output; no bypass path.
// Backpressure: o_ready reflects only the selected FIFO's fullness, so a stalled consumer blocks just its own traffic.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int ParamA     = 10,
   parameter int ParamDepth = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_sel,
   input  logic [ParamA-1:0] i_data,
   output logic              o_valid [0:NumOut-1],
   input  logic              i_ready [0:NumOut-1],
   output logic [ParamA-1:0] o_data  [0:NumOut-1]
`ifdef STREAM_DEMUX_COUNT_EN
   ,
   output count_t            o_count [0:NumOut-1]
`endif
);
   logic full  [NumOut];
   logic empty [NumOut];
   logic push  [NumOut];
   logic pop   [NumOut];

   // deliberately independent of i_ready: a pop never frees space in the same cycle
   assign o_ready = !full[i_sel];

   for (genvar k = 0; k < NumOut; k++) begin : g_out
      assign push[k]    = i_valid && o_ready && (i_sel == 1'(k));
      assign pop[k]     = o_valid[k] && i_ready[k];
      assign o_valid[k] = !empty[k];

      stream_demux_fifo #(
         .ParamA     (ParamA),
         .ParamDepth (ParamDepth)
      ) u_fifo (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_push  (push[k]),
         .i_data  (i_data),
         .o_full  (full[k]),
         .i_pop   (pop[k]),
         .o_data  (o_data[k]),
         .o_empty (empty[k])
      );

`ifdef STREAM_DEMUX_COUNT_EN
      count_t count_q, count_d;

      assign count_d    = count_q + 1'b1;
      assign o_count[k] = count_q;

      always_ff @(posedge i_clk or negedge i_rst) begin
         if (!i_rst)      count_q <= '0;
         else if (pop[k]) count_q <= count_d;
      end
`endif
   end
endmodule

// File: tb/tb_stream_demux.sv
// Randomised and directed scoreboard bench for stream_demux against a queue-based reference model.
module tb_stream_demux;
   import stream_demux_pkg::*;

   localparam int W = 10;
   localparam int D = 2;
   typedef logic [W-1:0] w_t;

   logic   clk = 1'b0;
   logic   rst_n;
   logic   vld;
   logic   sel;
   w_t     dat;
   logic   rdy_o;
   logic   ov [0:1];
   logic   ir [0:1];
   w_t     od [0:1];
`ifdef STREAM_DEMUX_COUNT_EN
   count_t cnt [0:1];
`endif

   w_t mq [2][$];
   int pops [2];
   int n_chk  = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   always #10 clk = ~clk;

   stream_demux #(.ParamA(W), .ParamDepth(D)) dut (
      .i_clk   (clk),
      .i_rst   (rst_n),
      .i_valid (vld),
      .o_ready (rdy_o),
      .i_sel   (sel),
      .i_data  (dat),
      .o_valid (ov),
      .i_ready (ir),
      .o_data  (od)
`ifdef STREAM_DEMUX_COUNT_EN
      ,
      .o_count (cnt)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   // One clock cycle of stimulus; the model decides acceptance from its own occupancy.
   task automatic cycle(input bit v, input bit s, input w_t d, input bit r0, input bit r1,
                        output bit acc);
      @(negedge clk);
      vld = v; sel = s; dat = d; ir[0] = r0; ir[1] = r1;
      #1;
      acc = 1'b0;
      if (rst_n) begin
         chk("o_ready", {31'd0, rdy_o}, {31'd0, mq[s].size() < D});
         acc = v && (mq[s].size() < D);
      end
      #2;
      if (acc) mq[s].push_back(d);
   endtask

   task automatic send(input bit s, input w_t d, input bit r0, input bit r1);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         cycle(1'b1, s, d, r0, r1, acc);
         n++;
      end
      chk("send_accepted", {31'd0, acc}, 32'd1);
   endtask

   task automatic idle(input int n, input bit r0, input bit r1);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, r0, r1, acc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((mq[0].size() + mq[1].size()) != 0 && n < 100) begin
         idle(1, 1'b1, 1'b1);
         n++;
      end
      chk("drained", mq[0].size() + mq[1].size(), 32'd0);
      idle(1, 1'b1, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      vld = 1'b0; sel = 1'b0;
      #5;
      rst_n = 1'b0;
      mq[0].delete(); mq[1].delete();
      pops[0] = 0; pops[1] = 0;
      #1;
      chk("rst_o_valid0", {31'd0, ov[0]}, 32'd0);
      chk("rst_o_valid1", {31'd0, ov[1]}, 32'd0);
      chk("rst_o_data0", {22'd0, od[0]}, 32'd0);
      chk("rst_o_data1", {22'd0, od[1]}, 32'd0);
      chk("rst_o_ready_sel0", {31'd0, rdy_o}, 32'd1);
      sel = 1'b1;
      #1;
      chk("rst_o_ready_sel1", {31'd0, rdy_o}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: compares DUT outputs with the scoreboard head and retires words on handshake.
   initial begin
      bit ev;
      wait (mon_en);
      forever begin
         @(negedge clk);
         #2;
         for (int k = 0; k < 2; k++) begin
            ev = (mq[k].size() > 0);
            chk($sformatf("o_valid[%0d]", k), {31'd0, ov[k]}, {31'd0, ev});
            if (ev) begin
               chk($sformatf("o_data[%0d]", k), {22'd0, od[k]}, {22'd0, mq[k][0]});
               if (ir[k]) begin
                  void'(mq[k].pop_front());
                  pops[k]++;
               end
            end
         end
      end
   end

   initial begin
      bit acc;
      rst_n = 1'b0; vld = 1'b0; sel = 1'b0; dat = '0;
      ir[0] = 1'b0; ir[1] = 1'b0;
      pops[0] = 0; pops[1] = 0;
      #5;
      chk("init_o_valid0", {31'd0, ov[0]}, 32'd0);
      chk("init_o_valid1", {31'd0, ov[1]}, 32'd0);
      chk("init_o_data0", {22'd0, od[0]}, 32'd0);
      chk("init_o_ready", {31'd0, rdy_o}, 32'd1);
      mon_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // routing
      send(1'b0, 10'h155, 1'b1, 1'b1);
      send(1'b1, 10'h2AA, 1'b1, 1'b1);
      drain();

      // backpressure, full, then release
      send(1'b0, 10'h001, 1'b0, 1'b0);
      send(1'b0, 10'h002, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 10'h003, 1'b0, 1'b0, acc);
      chk("full_no_accept", {31'd0, acc}, 32'd0);
      send(1'b0, 10'h003, 1'b1, 1'b0);
      drain();

      // isolation: output 0 full and stalled, output 1 still flows
      send(1'b0, 10'h0F0, 1'b0, 1'b0);
      send(1'b0, 10'h0F1, 1'b0, 1'b0);
      send(1'b1, 10'h3FF, 1'b0, 1'b1);
      idle(3, 1'b0, 1'b1);
      drain();

      // full-with-pop and 20-word stream on output 1
      send(1'b1, 10'h101, 1'b0, 1'b0);
      send(1'b1, 10'h102, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) send(1'b1, w_t'(10'h200 + i), 1'b0, 1'b1);
      drain();

      // asynchronous reset mid-stream with FIFO0 holding two words
      send(1'b0, 10'h011, 1'b0, 1'b0);
      send(1'b0, 10'h022, 1'b0, 1'b0);
      do_reset();
      send(1'b0, 10'h0AB, 1'b1, 1'b1);
      drain();

      // randomised traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), w_t'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), acc);
      end
      drain();

`ifdef STREAM_DEMUX_COUNT_EN
      chk("count0_model", {16'd0, cnt[0]}, {16'd0, 16'(pops[0])});
      chk("count1_model", {16'd0, cnt[1]}, {16'd0, 16'(pops[1])});
      do_reset();
      chk("count0_reset", {16'd0, cnt[0]}, 32'd0);
      for (int i = 0; i < 65537; i++) send(1'b0, w_t'(i), 1'b1, 1'b0);
      drain();
      chk("count0_wrap", {16'd0, cnt[0]}, 32'd1);
      chk("count1_idle", {16'd0, cnt[1]}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
